sram_bus_arbiter: RTL and testbench



---
 rtl/bus_pkg.sv | 24 ++
 rtl/sram_wait_counter.sv | 28 ++
 rtl/sram_bus_arbiter.sv | 198 +++++++++++++++++++
 tb/tb_sram_bus_arbiter.sv | 296 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bus_pkg.sv
// Shared definitions for the CPU-to-SRAM arbiter: FSM encoding, grant type,
// SRAM word-address geometry and the wait-counter width.
package bus_pkg;

    localparam logic [2:0] ST_IDLE     = 3'd0;
    localparam logic [2:0] ST_RD       = 3'd1;
    localparam logic [2:0] ST_WR_SETUP = 3'd2;
    localparam logic [2:0] ST_WR_PULSE = 3'd3;
    localparam logic [2:0] ST_WR_HOLD  = 3'd4;
    localparam logic [2:0] ST_DONE     = 3'd5;

    typedef enum logic {
        GNT_IF  = 1'b0,
        GNT_MEM = 1'b1
    } grant_t;

    // SRAM word address is byte address bits [21:2]
    localparam int SRAM_AW = 20;
    localparam int WA_LSB  = 2;
    localparam int WA_MSB  = WA_LSB + SRAM_AW - 1;

    localparam int CNT_W = 8;

endpackage

// File: rtl/sram_wait_counter.sv
// Loadable down-counter with a zero flag; times the read strobe and the
// write pulse so both phases share one counter.
module sram_wait_counter
    import bus_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    input  logic             dec,
    output logic             zero
);

    logic [CNT_W-1:0] count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (dec && (count != '0)) begin
            count <= count - 1'b1;
        end
    end

    assign zero = (count == '0);

endmodule

// File: rtl/sram_bus_arbiter.sv
// Arbitrates CPU IF and MEM ports onto the base/ext SRAM banks with registered,
// multi-cycle strobe timing and a one-cycle ack per completed access.
module sram_bus_arbiter
    import bus_pkg::*;
#(
    parameter int READ_WAIT   = 1,
    parameter int WRITE_PULSE = 2,
    parameter int BANK_BIT    = 22
)
(
    input  logic                clk,
    input  logic                rst_n,
    input  logic                if_req,
    input  logic [31:0]         if_addr,
    output logic                if_ack,
    output logic [31:0]         if_rdata,
    input  logic                mem_req,
    input  logic                mem_we,
    input  logic [31:0]         mem_addr,
    input  logic [3:0]          mem_sel,
    input  logic [31:0]         mem_wdata,
    output logic                mem_ack,
    output logic [31:0]         mem_rdata,
    output logic [SRAM_AW-1:0]  base_ram_addr,
    output logic [3:0]          base_ram_be_n,
    output logic                base_ram_ce_n,
    output logic                base_ram_oe_n,
    output logic                base_ram_we_n,
    output logic                base_ram_data_oe,
    input  logic [31:0]         base_ram_rdata,
    output logic [SRAM_AW-1:0]  ext_ram_addr,
    output logic [3:0]          ext_ram_be_n,
    output logic                ext_ram_ce_n,
    output logic                ext_ram_oe_n,
    output logic                ext_ram_we_n,
    output logic                ext_ram_data_oe,
    input  logic [31:0]         ext_ram_rdata,
    output logic [31:0]         ram_wdata
);

    logic [2:0]         state;
    grant_t             gnt;
    grant_t             last_grant;
    logic [SRAM_AW-1:0] lat_addr;
    logic [3:0]         lat_be_n;
    logic [31:0]        lat_wdata;
    logic               lat_we;
    logic               lat_bank;

    logic               pick_mem;
    logic               cnt_load;
    logic               cnt_dec;
    logic               cnt_zero;
    logic [CNT_W-1:0]   cnt_val;
    logic               wr_phase;
    logic               active;
    logic [31:0]        bank_rdata;
    logic               unused_addr_bits;

    // Upper and byte-lane address bits are decoded by the caller
    assign unused_addr_bits = ^{if_addr, mem_addr};

    // On contention MEM wins unless it won last time, so IF cannot starve
    always_comb begin
        pick_mem = 1'b0;
        if (mem_req && if_req) begin
            pick_mem = (last_grant != GNT_MEM);
        end else if (mem_req) begin
            pick_mem = 1'b1;
        end
    end

    always_comb begin
        cnt_load = 1'b0;
        cnt_val  = '0;
        cnt_dec  = 1'b0;
        case (state)
            ST_IDLE: begin
                cnt_load = 1'b1;
                cnt_val  = CNT_W'(READ_WAIT);
            end
            ST_WR_SETUP: begin
                cnt_load = 1'b1;
                cnt_val  = CNT_W'(WRITE_PULSE - 1);
            end
            ST_RD, ST_WR_PULSE: cnt_dec = !cnt_zero;
            default: ;
        endcase
    end

    sram_wait_counter u_wait_counter (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (cnt_load),
        .load_val (cnt_val),
        .dec      (cnt_dec),
        .zero     (cnt_zero)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            gnt        <= GNT_IF;
            last_grant <= GNT_IF;
            lat_addr   <= '0;
            lat_be_n   <= 4'hF;
            lat_wdata  <= '0;
            lat_we     <= 1'b0;
            lat_bank   <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (pick_mem) begin
                        gnt        <= GNT_MEM;
                        last_grant <= GNT_MEM;
                        lat_addr   <= mem_addr[WA_MSB:WA_LSB];
                        lat_be_n   <= ~mem_sel;
                        lat_wdata  <= mem_wdata;
                        lat_we     <= mem_we;
                        lat_bank   <= mem_addr[BANK_BIT];
                        state      <= mem_we ? ST_WR_SETUP : ST_RD;
                    end else if (if_req) begin
                        gnt        <= GNT_IF;
                        last_grant <= GNT_IF;
                        lat_addr   <= if_addr[WA_MSB:WA_LSB];
                        lat_be_n   <= 4'h0;
                        lat_wdata  <= '0;
                        lat_we     <= 1'b0;
                        lat_bank   <= if_addr[BANK_BIT];
                        state      <= ST_RD;
                    end
                end
                ST_RD:       if (cnt_zero) state <= ST_DONE;
                ST_WR_SETUP: state <= ST_WR_PULSE;
                ST_WR_PULSE: if (cnt_zero) state <= ST_WR_HOLD;
                ST_WR_HOLD:  state <= ST_DONE;
                ST_DONE:     state <= ST_IDLE;
                default:     state <= ST_IDLE;
            endcase
        end
    end

    // Pins are registered from the current state, so they trail it by one
    // cycle; DONE's last strobe cycle is where read data is sampled.
    assign wr_phase   = (state == ST_WR_SETUP) || (state == ST_WR_PULSE) || (state == ST_WR_HOLD);
    assign active     = wr_phase || (state == ST_RD);
    assign bank_rdata = lat_bank ? ext_ram_rdata : base_ram_rdata;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            base_ram_addr    <= '0;
            base_ram_be_n    <= 4'hF;
            base_ram_ce_n    <= 1'b1;
            base_ram_oe_n    <= 1'b1;
            base_ram_we_n    <= 1'b1;
            base_ram_data_oe <= 1'b0;
            ext_ram_addr     <= '0;
            ext_ram_be_n     <= 4'hF;
            ext_ram_ce_n     <= 1'b1;
            ext_ram_oe_n     <= 1'b1;
            ext_ram_we_n     <= 1'b1;
            ext_ram_data_oe  <= 1'b0;
            ram_wdata        <= '0;
            if_ack           <= 1'b0;
            mem_ack          <= 1'b0;
            if_rdata         <= '0;
            mem_rdata        <= '0;
        end else begin
            base_ram_ce_n    <= !(active && !lat_bank);
            base_ram_oe_n    <= !((state == ST_RD) && !lat_bank);
            base_ram_we_n    <= !((state == ST_WR_PULSE) && !lat_bank);
            base_ram_data_oe <= wr_phase && !lat_bank;
            base_ram_be_n    <= (active && !lat_bank) ? lat_be_n : 4'hF;
            ext_ram_ce_n     <= !(active && lat_bank);
            ext_ram_oe_n     <= !((state == ST_RD) && lat_bank);
            ext_ram_we_n     <= !((state == ST_WR_PULSE) && lat_bank);
            ext_ram_data_oe  <= wr_phase && lat_bank;
            ext_ram_be_n     <= (active && lat_bank) ? lat_be_n : 4'hF;
            if (active) begin
                base_ram_addr <= lat_addr;
                ext_ram_addr  <= lat_addr;
            end
            if (wr_phase) begin
                ram_wdata <= lat_wdata;
            end
            if_ack  <= (state == ST_DONE) && (gnt == GNT_IF);
            mem_ack <= (state == ST_DONE) && (gnt == GNT_MEM);
            if ((state == ST_DONE) && !lat_we) begin
                if (gnt == GNT_IF) begin
                    if_rdata <= bank_rdata;
                end else begin
                    mem_rdata <= bank_rdata;
                end
            end
        end
    end

endmodule

// File: tb/tb_sram_bus_arbiter.sv
// Directed bench for sram_bus_arbiter: reset, IF/MEM reads and writes,
// fair arbitration, dropped requests and reset during a write pulse.
module tb_sram_bus_arbiter;

    logic        clk;
    logic        rst_n;
    logic        if_req;
    logic [31:0] if_addr;
    logic        if_ack;
    logic [31:0] if_rdata;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [3:0]  mem_sel;
    logic [31:0] mem_wdata;
    logic        mem_ack;
    logic [31:0] mem_rdata;
    logic [19:0] base_ram_addr;
    logic [3:0]  base_ram_be_n;
    logic        base_ram_ce_n;
    logic        base_ram_oe_n;
    logic        base_ram_we_n;
    logic        base_ram_data_oe;
    logic [31:0] base_ram_rdata;
    logic [19:0] ext_ram_addr;
    logic [3:0]  ext_ram_be_n;
    logic        ext_ram_ce_n;
    logic        ext_ram_oe_n;
    logic        ext_ram_we_n;
    logic        ext_ram_data_oe;
    logic [31:0] ext_ram_rdata;
    logic [31:0] ram_wdata;

    int tests_run;
    int tests_failed;

    // expected grant order (0 = IF, 1 = MEM)
    logic [31:0] exp_q[$];

    // per-access observations
    int          ack_at;
    int          n_if_ack, n_mem_ack, n_both;
    int          n_base_ce, n_base_oe, n_base_we, n_base_doe;
    int          n_ext_ce, n_ext_oe, n_ext_we, n_ext_doe;
    logic [19:0] base_addr_seen, ext_addr_seen;
    logic [3:0]  base_be_seen, ext_be_seen;
    logic [31:0] wdata_seen;

    sram_bus_arbiter dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .if_req           (if_req),
        .if_addr          (if_addr),
        .if_ack           (if_ack),
        .if_rdata         (if_rdata),
        .mem_req          (mem_req),
        .mem_we           (mem_we),
        .mem_addr         (mem_addr),
        .mem_sel          (mem_sel),
        .mem_wdata        (mem_wdata),
        .mem_ack          (mem_ack),
        .mem_rdata        (mem_rdata),
        .base_ram_addr    (base_ram_addr),
        .base_ram_be_n    (base_ram_be_n),
        .base_ram_ce_n    (base_ram_ce_n),
        .base_ram_oe_n    (base_ram_oe_n),
        .base_ram_we_n    (base_ram_we_n),
        .base_ram_data_oe (base_ram_data_oe),
        .base_ram_rdata   (base_ram_rdata),
        .ext_ram_addr     (ext_ram_addr),
        .ext_ram_be_n     (ext_ram_be_n),
        .ext_ram_ce_n     (ext_ram_ce_n),
        .ext_ram_oe_n     (ext_ram_oe_n),
        .ext_ram_we_n     (ext_ram_we_n),
        .ext_ram_data_oe  (ext_ram_data_oe),
        .ext_ram_rdata    (ext_ram_rdata),
        .ram_wdata        (ram_wdata)
    );

    // clock / reset
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        if (obs !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // driver tasks: called at a negedge, the grant edge is the next posedge
    task automatic drive_if(input logic [31:0] addr);
        if_addr = addr;
        if_req  = 1'b1;
    endtask

    task automatic drive_mem(input logic we, input logic [31:0] addr,
                             input logic [3:0] sel, input logic [31:0] wdata);
        mem_we    = we;
        mem_addr  = addr;
        mem_sel   = sel;
        mem_wdata = wdata;
        mem_req   = 1'b1;
    endtask

    // Observe `budget` cycles; cycle k is sampled at the k-th negedge after
    // the grant edge. Requests drop on ack, or at cycle drop_at if nonzero.
    task automatic watch(input int budget, input int drop_at);
        ack_at = 0; n_if_ack = 0; n_mem_ack = 0; n_both = 0;
        n_base_ce = 0; n_base_oe = 0; n_base_we = 0; n_base_doe = 0;
        n_ext_ce = 0; n_ext_oe = 0; n_ext_we = 0; n_ext_doe = 0;
        base_addr_seen = '0; ext_addr_seen = '0;
        base_be_seen = 4'hF; ext_be_seen = 4'hF; wdata_seen = '0;
        for (int k = 1; k <= budget; k++) begin
            @(negedge clk);
            if (k == drop_at) begin
                if_req  = 1'b0;
                mem_req = 1'b0;
            end
            if (!base_ram_ce_n) begin
                n_base_ce++;
                base_addr_seen = base_ram_addr;
                base_be_seen   = base_ram_be_n;
            end
            if (!base_ram_oe_n) n_base_oe++;
            if (!base_ram_we_n) begin
                n_base_we++;
                wdata_seen = ram_wdata;
            end
            if (base_ram_data_oe) n_base_doe++;
            if (!ext_ram_ce_n) begin
                n_ext_ce++;
                ext_addr_seen = ext_ram_addr;
                ext_be_seen   = ext_ram_be_n;
            end
            if (!ext_ram_oe_n) n_ext_oe++;
            if (!ext_ram_we_n) begin
                n_ext_we++;
                wdata_seen = ram_wdata;
            end
            if (ext_ram_data_oe) n_ext_doe++;
            if (if_ack && mem_ack) n_both++;
            if (if_ack) n_if_ack++;
            if (mem_ack) n_mem_ack++;
            if (if_ack || mem_ack) begin
                if (ack_at == 0) ack_at = k;
                if_req  = 1'b0;
                mem_req = 1'b0;
            end
        end
    endtask

    initial begin
        int          n_acks;
        int          got;
        logic [31:0] exp_g;
        logic        model_last_mem;

        tests_run = 0; tests_failed = 0;
        rst_n = 1'b0;
        if_req = 1'b0; if_addr = '0;
        mem_req = 1'b0; mem_we = 1'b0; mem_addr = '0; mem_sel = 4'h0; mem_wdata = '0;
        base_ram_rdata = '0; ext_ram_rdata = '0;

        // reset state
        repeat (3) @(negedge clk);
        check("rst_strobes", {26'd0, base_ram_ce_n, base_ram_oe_n, base_ram_we_n,
                              ext_ram_ce_n, ext_ram_oe_n, ext_ram_we_n}, 32'h3F);
        check("rst_be_n", {24'd0, base_ram_be_n, ext_ram_be_n}, 32'hFF);
        check("rst_addr", {12'd0, base_ram_addr} | {12'd0, ext_ram_addr}, 32'h0);
        check("rst_oe_acks", {28'd0, base_ram_data_oe, ext_ram_data_oe, if_ack, mem_ack}, 32'h0);
        check("rst_rdata", if_rdata | mem_rdata | ram_wdata, 32'h0);
        rst_n = 1'b1;
        @(negedge clk);

        // IF read from base
        base_ram_rdata = 32'hDEADBEEF;
        drive_if(32'h0000_0010);
        watch(10, 0);
        check("if_rd_ack_at", ack_at, 4);
        check("if_rd_ce_cycles", n_base_ce, 2);
        check("if_rd_oe_cycles", n_base_oe, 2);
        check("if_rd_addr", {12'd0, base_addr_seen}, 32'h4);
        check("if_rd_be_n", {28'd0, base_be_seen}, 32'h0);
        check("if_rd_ext_idle", n_ext_ce + n_ext_oe + n_base_we, 0);
        check("if_rd_acks", {n_if_ack[15:0], n_mem_ack[15:0]}, 32'h0001_0000);
        check("if_rd_rdata", if_rdata, 32'hDEADBEEF);
        check("if_rd_mem_rdata", mem_rdata, 32'h0);

        // contention: last grant is IF, so MEM first, then alternate
        model_last_mem = 1'b0;
        for (int i = 0; i < 4; i++) begin
            model_last_mem = !model_last_mem;
            exp_q.push_back({31'd0, model_last_mem});
        end
        base_ram_rdata = 32'h0BADF00D;
        drive_mem(1'b0, 32'h0000_0100, 4'hF, 32'h0);
        drive_if(32'h0000_0200);
        n_acks = 0; n_both = 0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (if_ack && mem_ack) n_both++;
            if (if_ack || mem_ack) begin
                got = mem_ack ? 1 : 0;
                if (exp_q.size() > 0) begin
                    exp_g = exp_q.pop_front();
                    check("arb_order", got, exp_g);
                end
                n_acks++;
                if (n_acks == 4) begin
                    if_req  = 1'b0;
                    mem_req = 1'b0;
                end
            end
        end
        check("arb_ack_count", n_acks, 4);
        check("arb_coincident", n_both, 0);
        check("arb_if_rdata", if_rdata, 32'h0BADF00D);
        check("arb_mem_rdata", mem_rdata, 32'h0BADF00D);

        // MEM write to ext bank
        drive_mem(1'b1, 32'h0040_0008, 4'b0011, 32'h12345678);
        watch(10, 0);
        check("wr_ack_at", ack_at, 6);
        check("wr_we_cycles", n_ext_we, 2);
        check("wr_data_oe_cycles", n_ext_doe, 4);
        check("wr_ce_cycles", n_ext_ce, 4);
        check("wr_oe_unused", n_ext_oe, 0);
        check("wr_base_idle", n_base_ce + n_base_oe + n_base_we + n_base_doe, 0);
        check("wr_addr", {12'd0, ext_addr_seen}, 32'h2);
        check("wr_be_n", {28'd0, ext_be_seen}, 32'hC);
        check("wr_wdata", wdata_seen, 32'h12345678);
        check("wr_mem_acks", n_mem_ack, 1);
        check("wr_mem_rdata_kept", mem_rdata, 32'h0BADF00D);

        // MEM read from ext; IF data must not move
        ext_ram_rdata = 32'hA5A5A5A5;
        drive_mem(1'b0, 32'h0040_0000, 4'hF, 32'h0);
        watch(10, 0);
        check("mem_rd_ack_at", ack_at, 4);
        check("mem_rd_ext_oe", n_ext_oe, 2);
        check("mem_rd_rdata", mem_rdata, 32'hA5A5A5A5);
        check("mem_rd_if_kept", if_rdata, 32'h0BADF00D);

        // write with req dropped one cycle after grant
        drive_mem(1'b1, 32'h0000_0020, 4'hF, 32'hCAFE0001);
        watch(12, 1);
        check("drop_ack_at", ack_at, 6);
        check("drop_we_cycles", n_base_we, 2);
        check("drop_mem_acks", n_mem_ack, 1);
        check("drop_addr", {12'd0, base_addr_seen}, 32'h8);

        // write with no byte enables still runs to completion
        drive_mem(1'b1, 32'h0000_0030, 4'h0, 32'h55AA55AA);
        watch(10, 0);
        check("sel0_ack_at", ack_at, 6);
        check("sel0_be_n", {28'd0, base_be_seen}, 32'hF);
        check("sel0_we_cycles", n_base_we, 2);

        // reset asserted during the write pulse
        drive_mem(1'b1, 32'h0000_0040, 4'hF, 32'h0F0F0F0F);
        repeat (3) @(negedge clk);
        check("rst_mid_we_low", {31'd0, base_ram_we_n}, 32'h0);
        #2 rst_n = 1'b0;
        #1;
        check("rst_mid_we_async", {29'd0, base_ram_we_n, base_ram_ce_n, base_ram_data_oe}, 32'h6);
        mem_req = 1'b0;
        n_mem_ack = 0;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            if (mem_ack) n_mem_ack++;
            if (k == 2) rst_n = 1'b1;
        end
        check("rst_mid_no_ack", n_mem_ack, 0);

        // recovery after reset: plain IF read
        base_ram_rdata = 32'h13572468;
        drive_if(32'h0000_0010);
        watch(10, 0);
        check("post_rst_ack_at", ack_at, 4);
        check("post_rst_rdata", if_rdata, 32'h13572468);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
